priority_encoder_hs: RTL and testbench

PRIORITY_ENCODER_HS -- requirements
Module: priority_encoder_hs

---
 rtl/priority_encoder_hs.sv | 119 +++++++++++
 tb/tb_priority_encoder_hs.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_hs.sv
// -----------------------------------------------------------------------------
// priority_encoder_hs
//
// Captures request strobes into a pending register and presents the
// highest-index pending line to a consumer with a valid/ack handshake.
// A presented line is held stable until acknowledged (no preemption), and
// acknowledged lines are retired from the pending set. Requests that land
// on a line that is already pending are merged and flagged with DROP.
//
// Ports
//   clk    in   1  rising-edge clock for all state
//   rst_n  in   1  asynchronous active-low reset
//   E      in   1  enable; D is ignored while low
//   D      in   4  request strobes, one bit per line
//   ack    in   1  consumer accepts the presented A while V is high
//   A      out  2  index of the presented line (registered)
//   V      out  1  A is valid (registered)
//   P      out  4  pending-request register
//   DROP   out  1  one-cycle pulse: a request merged into a pending line
// -----------------------------------------------------------------------------
module priority_encoder_hs (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       E,
  input  logic [3:0] D,
  input  logic       ack,
  output logic [1:0] A,
  output logic       V,
  output logic [3:0] P,
  output logic       DROP
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] a_reg, a_next;
  logic [3:0] pend_reg, pend_next;
  logic       drop_reg, drop_next;

  logic [3:0] clr;
  logic [3:0] req_in;

  // Fixed priority: line 3 highest, line 0 lowest.
  function automatic logic [1:0] top_index(input logic [3:0] req);
    logic [1:0] idx;
    idx = 2'd0;
    if (req[3])      idx = 2'd3;
    else if (req[2]) idx = 2'd2;
    else if (req[1]) idx = 2'd1;
    else             idx = 2'd0;
    return idx;
  endfunction

  // Retire the presented line only on an accepted handshake; ack while
  // nothing is presented has no effect.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_clr
      assign clr[gi] = (state_reg == HOLD) && ack && (a_reg == gi[1:0]);
    end
  endgenerate

  assign req_in = E ? D : 4'b0000;

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    // Set is OR-ed after the clear so a coincident new request survives.
    pend_next  = (pend_reg & ~clr) | req_in;
    // A request on a line being retired this cycle is new, not a merge.
    drop_next  = |(req_in & pend_reg & ~clr);

    case (state_reg)
      IDLE: begin
        if (pend_reg != 4'b0000) begin
          a_next     = top_index(pend_reg);
          state_next = HOLD;
        end
      end
      HOLD: begin
        // Without ack the presented line is frozen, even if a higher
        // line arrives. With ack, move straight to the next line using
        // the updated pending set so there is no idle bubble.
        if (ack) begin
          if (pend_next != 4'b0000) begin
            a_next = top_index(pend_next);
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= 2'b00;
      pend_reg  <= 4'b0000;
      drop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      pend_reg  <= pend_next;
      drop_reg  <= drop_next;
    end
  end

  assign A    = a_reg;
  assign V    = (state_reg == HOLD);
  assign P    = pend_reg;
  assign DROP = drop_reg;

endmodule

// File: tb/tb_priority_encoder_hs.sv
// -----------------------------------------------------------------------------
// tb_priority_encoder_hs
//
// Directed-vector bench for priority_encoder_hs. Inputs are driven 1 ns
// after each rising edge and outputs are checked at the same point, so each
// "cycle" below is the interval following an edge.
// -----------------------------------------------------------------------------
module tb_priority_encoder_hs;

  logic       clk;
  logic       rst_n;
  logic       E;
  logic [3:0] D;
  logic       ack;
  logic [1:0] A;
  logic       V;
  logic [3:0] P;
  logic       DROP;

  int n_checks;
  int n_fail;

  priority_encoder_hs dut (
    .clk  (clk),
    .rst_n(rst_n),
    .E    (E),
    .D    (D),
    .ack  (ack),
    .A    (A),
    .V    (V),
    .P    (P),
    .DROP (DROP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [1:0] ea, input logic ev,
                           input logic [3:0] ep, input logic ed);
    check({tag, ".V"},    {7'b0, V},    {7'b0, ev});
    if (ev) check({tag, ".A"}, {6'b0, A}, {6'b0, ea});
    check({tag, ".P"},    {4'b0, P},    {4'b0, ep});
    check({tag, ".DROP"}, {7'b0, DROP}, {7'b0, ed});
    $display("cycle %s: A=%0d V=%0b P=%b DROP=%0b", tag, A, V, P, DROP);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    E     = 1'b1;
    D     = 4'b1111;
    ack   = 1'b0;

    // Reset held with active requests: everything stays cleared.
    #1;
    check("rst_async.A", {6'b0, A}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_hold.A", {6'b0, A}, 8'h00);
      check_out("rst_hold", 2'd0, 1'b0, 4'b0000, 1'b0);
    end

    // Release; the very next edge samples D.
    rst_n = 1'b1;
    step();
    check_out("rst_release", 2'd0, 1'b0, 4'b1111, 1'b0);
    D = 4'b0000;
    step();
    check_out("pre_midhold", 2'd3, 1'b1, 4'b1111, 1'b0);

    // Asynchronous reset in the middle of HOLD discards everything.
    rst_n = 1'b0;
    #1;
    check("midhold_rst.A", {6'b0, A}, 8'h00);
    check_out("midhold_rst", 2'd0, 1'b0, 4'b0000, 1'b0);
    step();
    rst_n = 1'b1;
    ack   = 1'b1;
    step();
    check_out("quiet", 2'd0, 1'b0, 4'b0000, 1'b0);

    // Single request, ack held high.
    D = 4'b0100;
    step();
    D = 4'b0000;
    check_out("single_n1", 2'd0, 1'b0, 4'b0100, 1'b0);
    step();
    check_out("single_n2", 2'd2, 1'b1, 4'b0100, 1'b0);
    step();
    check_out("single_n3", 2'd0, 1'b0, 4'b0000, 1'b0);

    // Multi-bit capture, priority order and back-to-back service.
    D = 4'b1011;
    step();
    D = 4'b0000;
    check_out("b2b_cap", 2'd0, 1'b0, 4'b1011, 1'b0);
    step();
    check_out("b2b_a3", 2'd3, 1'b1, 4'b1011, 1'b0);
    step();
    check_out("b2b_a1", 2'd1, 1'b1, 4'b0011, 1'b0);
    step();
    check_out("b2b_a0", 2'd0, 1'b1, 4'b0001, 1'b0);
    step();
    check_out("b2b_end", 2'd0, 1'b0, 4'b0000, 1'b0);

    // No preemption by a higher line while unacknowledged.
    ack = 1'b0;
    D   = 4'b0001;
    step();
    D = 4'b0000;
    check_out("nopre_cap", 2'd0, 1'b0, 4'b0001, 1'b0);
    step();
    check_out("nopre_a0", 2'd0, 1'b1, 4'b0001, 1'b0);
    D = 4'b1000;
    step();
    D = 4'b0000;
    check_out("nopre_hold1", 2'd0, 1'b1, 4'b1001, 1'b0);
    step();
    check_out("nopre_hold2", 2'd0, 1'b1, 4'b1001, 1'b0);
    ack = 1'b1;
    step();
    check_out("nopre_a3", 2'd3, 1'b1, 4'b1000, 1'b0);
    step();
    check_out("nopre_end", 2'd0, 1'b0, 4'b0000, 1'b0);

    // Merge into a pending line produces a one-cycle DROP.
    ack = 1'b0;
    D   = 4'b0010;
    step();
    check_out("drop_first", 2'd0, 1'b0, 4'b0010, 1'b0);
    step();
    D = 4'b0000;
    check_out("drop_pulse", 2'd1, 1'b1, 4'b0010, 1'b1);
    step();
    check_out("drop_gone", 2'd1, 1'b1, 4'b0010, 1'b0);

    // Request coincident with the ack retiring the same line: not a drop.
    ack = 1'b1;
    D   = 4'b0010;
    step();
    D = 4'b0000;
    check_out("coincident", 2'd1, 1'b1, 4'b0010, 1'b0);
    step();
    check_out("coinc_end", 2'd0, 1'b0, 4'b0000, 1'b0);

    // Enable low: requests ignored.
    E = 1'b0;
    D = 4'b1111;
    step();
    check_out("gate_ign1", 2'd0, 1'b0, 4'b0000, 1'b0);
    step();
    check_out("gate_ign2", 2'd0, 1'b0, 4'b0000, 1'b0);

    // Enable low does not stall lines already pending.
    E = 1'b1;
    D = 4'b0101;
    step();
    E = 1'b0;
    D = 4'b1111;
    check_out("gate_cap", 2'd0, 1'b0, 4'b0101, 1'b0);
    step();
    check_out("gate_a2", 2'd2, 1'b1, 4'b0101, 1'b0);
    step();
    check_out("gate_a0", 2'd0, 1'b1, 4'b0001, 1'b0);
    step();
    check_out("gate_end", 2'd0, 1'b0, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
